// File: rtl/switch_input_pkg.sv
// Shared switch-bus and instruction-phase definitions for switch_input and its register-file consumer.
// Pure definitions: no logic, no latency, no backpressure.
`ifndef SWITCH_WIDTH
`define SWITCH_WIDTH 10
`endif
`ifndef CYCLE_SIZE
`define CYCLE_SIZE 3
`endif
`ifndef CYCLE_DECODE
`define CYCLE_DECODE 0
`endif
`ifndef CYCLE_EXEC
`define CYCLE_EXEC 1
`endif
`ifndef CYCLE_WRITE
`define CYCLE_WRITE 2
`endif

package switch_input_pkg;

   localparam int SW_BITS    = `SWITCH_WIDTH - 1;
   localparam int SW8_IDX    = SW_BITS - 1;
   localparam int CYC_W      = `CYCLE_SIZE;
   localparam int CYC_DECODE = `CYCLE_DECODE;
   localparam int CYC_EXEC   = `CYCLE_EXEC;
   localparam int CYC_WRITE  = `CYCLE_WRITE;

   typedef logic [`SWITCH_WIDTH-2:0] sw_bus_t;
   typedef logic [CYC_W-1:0]         cycle_t;

   // Exact one-hot patterns; anything else (zero, multi-hot) is not a valid phase.
   localparam cycle_t CYCLE_DECODE_OH = cycle_t'(1) << CYC_DECODE;
   localparam cycle_t CYCLE_EXEC_OH   = cycle_t'(1) << CYC_EXEC;
   localparam cycle_t CYCLE_WRITE_OH  = cycle_t'(1) << CYC_WRITE;

endpackage

// File: rtl/switch_input_bit_debounce.sv
// One switch bit: SYNC_STAGES-flop synchroniser then a persist-for-DEBOUNCE_CYCLES debouncer.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES clks from raw edge to level; no backpressure.
module bit_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic n_reset,
   input  logic raw,
   output logic level,
   output logic busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   s;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
      s       = sync_q[SYNC_STAGES-1];
      level_d = level_q;
      cnt_d   = '0;
      // Any return to the accepted level clears the count, so only an unbroken run is accepted.
      if (s != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = s;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;
   assign busy  = (cnt_q != '0);

endmodule

// File: rtl/switch_input.sv
// Conditioned switch bus for regs, republished only on the write-phase edge; optional SW8 one-shot via SW8_PULSE_EN.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES + 1..3 clks, phase-dependent; no backpressure.
module switch_input
   import switch_input_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic [CYC_W-1:0]   cycle,
   input  logic [SW_BITS-1:0] sw_raw,
   output logic [SW_BITS-1:0] switches,
   output logic               stable
);

   sw_bus_t level;
   sw_bus_t busy;
   sw_bus_t switches_q, switches_d;
   logic    publish;

   for (genvar i = 0; i < SW_BITS; i++) begin : g_bit
      bit_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .n_reset (n_reset),
         .raw     (sw_raw[i]),
         .level   (level[i]),
         .busy    (busy[i])
      );
   end

   assign publish = (cycle == CYCLE_WRITE_OH);

`ifdef SW8_PULSE_EN
   logic prev8_q, prev8_d;
   logic pulse_q, pulse_d;
   logic rise8;

   // A rise landing on the publish edge re-arms the flag for the following instruction.
   always_comb begin
      rise8      = level[SW8_IDX] & ~prev8_q;
      prev8_d    = level[SW8_IDX];
      pulse_d    = rise8 | (pulse_q & ~publish);
      switches_d = switches_q;
      if (publish) begin
         switches_d = {pulse_q, level[SW8_IDX-1:0]};
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         prev8_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         prev8_q <= prev8_d;
         pulse_q <= pulse_d;
      end
   end
`else
   always_comb begin
      switches_d = switches_q;
      if (publish) begin
         switches_d = level;
      end
   end
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         switches_q <= '0;
      end else begin
         switches_q <= switches_d;
      end
   end

   assign switches = switches_q;
   assign stable   = ~|busy;

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input: expected bus updates queue up at stimulus time, a monitor checks each change.
module tb_switch_input;
   import switch_input_pkg::*;

   logic               clk;
   logic               n_reset;
   logic [CYC_W-1:0]   cycle;
   logic [SW_BITS-1:0] sw_raw;
   logic [SW_BITS-1:0] switches;
   logic               stable;

   typedef struct {
      logic [SW_BITS-1:0] val;
      int                 lo;
      int                 hi;
      bit                 at_dec;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   edge_cnt = 0;

   switch_input #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .cycle    (cycle),
      .sw_raw   (sw_raw),
      .switches (switches),
      .stable   (stable)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Instruction cycle generator: decode -> exec -> write, one clk each.
   initial begin
      cycle = CYCLE_DECODE_OH;
      forever begin
         @(posedge clk);
         #1 cycle = {cycle[CYC_W-2:0], cycle[CYC_W-1]};
      end
   end

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, req, edge_cnt);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [SW_BITS-1:0] v, input int lo, input int hi, input bit at_dec);
      exp_t e;
      e.val = v; e.lo = lo; e.hi = hi; e.at_dec = at_dec;
      exp_q.push_back(e);
   endtask

   task automatic wait_phase(input logic [CYC_W-1:0] ph);
      for (int i = 0; i < 6 && cycle != ph; i++) tick();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      check(exp_q.size() == 0, name, exp_q.size(), 0);
   endtask

   // Monitor: every change of the bus must match the next queued expectation.
   initial begin
      logic [SW_BITS-1:0] prev;
      exp_t e;
      prev = '0;
      forever begin
         @(negedge clk);
         if (switches !== prev) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "sb_unexpected_change", switches, prev);
            end else begin
               e = exp_q.pop_front();
               check(switches === e.val, "sb_value", switches, e.val);
               check(edge_cnt >= e.lo, "sb_too_early", edge_cnt, e.lo);
               check(edge_cnt <= e.hi, "sb_too_late", edge_cnt, e.hi);
               if (e.at_dec) check(cycle == CYCLE_DECODE_OH, "sb_phase", cycle, CYCLE_DECODE_OH);
            end
            prev = switches;
         end
      end
   end

   initial begin
      #50us;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, s, ones, exp_ones;

      // Reset with all switches on
      n_reset = 1'b1;
      sw_raw  = 9'h1FF;
      #5 n_reset = 1'b0;
      repeat (4) tick();
      check(switches == 9'h000, "rst_switches", switches, 9'h000);
      check(stable == 1'b1, "rst_stable", stable, 1);
      sw_raw = 9'h000;
      repeat (3) tick();
      n_reset = 1'b1;
      repeat (3) tick();
      check(switches == 9'h000, "post_release", switches, 9'h000);

      // Clean change
      k = edge_cnt;
      sw_raw = 9'h0A5;
      push(9'h0A5, k + 7, k + 9, 1'b1);
      drain("drain_clean");
      check(switches == 9'h0A5, "clean_value", switches, 9'h0A5);

      // Reset dropped mid-exec clears the bus at once
      wait_phase(CYCLE_EXEC_OH);
      #3;
      push(9'h000, edge_cnt, edge_cnt, 1'b0);
      n_reset = 1'b0;
      #1;
      check(switches == 9'h000, "rst_mid_exec", switches, 9'h000);
      check(stable == 1'b1, "rst_mid_stable", stable, 1);
      tick();
      tick();
      n_reset = 1'b1;
      k = edge_cnt;
      push(9'h0A5, k + 7, k + 9, 1'b1);
      drain("drain_rerelease");

      // Bounce on SW3 (old level 0)
      sw_raw[3] = 1'b1; tick();
      sw_raw[3] = 1'b0; tick();
      sw_raw[3] = 1'b1; tick();
      sw_raw[3] = 1'b0;
      check(stable == 1'b0, "bounce_stable_a", stable, 0);
      check(switches == 9'h0A5, "bounce_hold_a", switches, 9'h0A5);
      tick();
      sw_raw[3] = 1'b1;
      s = edge_cnt;
      tick();
      check(stable == 1'b0, "bounce_stable_b", stable, 0);
      check(switches == 9'h0A5, "bounce_hold_b", switches, 9'h0A5);
      push(9'h0AD, s + 7, s + 9, 1'b1);
      drain("drain_bounce");

      // One-clk glitch on SW0
      sw_raw[0] = 1'b0; tick();
      sw_raw[0] = 1'b1; tick();
      tick();
      check(stable == 1'b0, "glitch_busy", stable, 0);
      tick();
      check(stable == 1'b1, "glitch_settled", stable, 1);
      repeat (12) tick();
      check(switches == 9'h0AD, "glitch_no_change", switches, 9'h0AD);

      // Debounced level lands during exec; bus waits for the write edge
      wait_phase(CYCLE_EXEC_OH);
      k = edge_cnt;
      sw_raw = 9'h0ED;
      push(9'h0ED, k + 8, k + 8, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (cycle == CYCLE_EXEC_OH) check(switches == 9'h0AD, "exec_hold", switches, 9'h0AD);
      end
      drain("drain_boundary");

      // SW8 held for 20 instructions
      wait_phase(CYCLE_DECODE_OH);
      k = edge_cnt;
      sw_raw[8] = 1'b1;
`ifdef SW8_PULSE_EN
      push(9'h1ED, k + 9, k + 9, 1'b1);
      push(9'h0ED, k + 12, k + 12, 1'b1);
      exp_ones = 1;
`else
      push(9'h1ED, k + 9, k + 9, 1'b1);
      exp_ones = 17;
`endif
      ones = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) repeat (3) tick();
         ones += int'(switches[8]);
      end
      check(ones == exp_ones, "sw8_instr_count", ones, exp_ones);
      drain("drain_sw8");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
